// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_display
// Purpose  : Countdown display driver. A binary count captured on a load
//            strobe is converted to BCD by a sequential double-dabble
//            engine, then shown on a time-multiplexed, active-low,
//            common-anode 7-segment bank. Supports leading-zero blanking,
//            overflow dashes and whole-display blinking.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous reset, active-high
//            value    - binary count to display (IN_W bits)
//            load     - one-cycle strobe, capture value
//            blank_lz - blank leading zeros when 1
//            blink_en - blink the whole display when 1
//            busy     - conversion in progress
//            ovf      - last committed value exceeded 10^DIGITS-1
//            seg      - segments g..a, active-low
//            an       - digit enables, active-low
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
  parameter int DIGITS       = 2,
  parameter int IN_W         = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   value,
  input  logic              load,
  input  logic              blank_lz,
  input  logic              blink_en,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  state_e             state_q,  state_d;
  logic [IN_W-1:0]    shift_q,  shift_d;
  logic [IN_W-1:0]    cap_q,    cap_d;
  logic [BCD_W-1:0]   bcd_q,    bcd_d;
  logic [CNT_W-1:0]   iter_q,   iter_d;
  logic [IN_W-1:0]    pend_q,   pend_d;
  logic               pend_v_q, pend_v_d;
  logic               busy_q,   busy_d;
  logic [BCD_W-1:0]   disp_q,   disp_d;
  logic               ovf_q,    ovf_d;
  logic [DIV_W-1:0]   div_q,    div_d;
  logic [IDX_W-1:0]   idx_q,    idx_d;
  logic [FRM_W-1:0]   frm_q,    frm_d;
  logic               phase_q,  phase_d;
  logic [6:0]         seg_q,    seg_d;
  logic [DIGITS-1:0]  an_q,     an_d;

  // One double-dabble step: add 3 to every nibble >= 5, then shift the
  // combined {bcd, shift} register left by one.
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W+IN_W-1:0] dd_all;

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    dd_all = {bcd_adj, shift_q} << 1;
  end

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // Conversion control
  logic            start;
  logic [IN_W-1:0] start_val;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cap_d     = cap_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    busy_d    = busy_q;
    disp_d    = disp_q;
    ovf_d     = ovf_q;
    start     = 1'b0;
    start_val = value;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          start   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        if (iter_q != CNT_W'(IN_W)) begin
          bcd_d   = dd_all[BCD_W+IN_W-1 -: BCD_W];
          shift_d = dd_all[IN_W-1:0];
          iter_d  = iter_q + CNT_W'(1);
          if (load) begin
            pend_d   = value;
            pend_v_d = 1'b1;
          end
        end else begin
          // Commit cycle: all IN_W shifts are done.
          disp_d = bcd_q;
          ovf_d  = ({{(32-IN_W){1'b0}}, cap_q} > MAX_VAL);
          if (pend_v_q) begin
            // Pending value converts next; a load arriving now becomes
            // the new pending entry so nothing is lost.
            start     = 1'b1;
            start_val = pend_q;
            pend_v_d  = load;
            if (load) begin
              pend_d = value;
            end
          end else if (load) begin
            start = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (start) begin
      shift_d = start_val;
      cap_d   = start_val;
      bcd_d   = '0;
      iter_d  = '0;
    end
  end

  // Scan, blink and registered output decode
  logic       div_wrap;
  logic       frame_wrap;
  logic [3:0] cur_nib;
  logic       hi_zero;

  always_comb begin
    div_d      = div_q + DIV_W'(1);
    idx_d      = idx_q;
    frm_d      = frm_q;
    phase_d    = phase_q;
    frame_wrap = 1'b0;
    div_wrap   = (div_q == DIV_W'(SCAN_DIV - 1));

    if (div_wrap) begin
      div_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d      = '0;
        frame_wrap = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (!blink_en) begin
      phase_d = 1'b0;
      frm_d   = '0;
    end else if (frame_wrap) begin
      if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end

    // Current digit and "this digit and everything above it is zero".
    cur_nib = 4'd0;
    hi_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (IDX_W'(k) == idx_q) begin
        cur_nib = disp_q[4*k +: 4];
      end
      if ((k >= int'(idx_q)) && (disp_q[4*k +: 4] != 4'd0)) begin
        hi_zero = 1'b0;
      end
    end

    an_d = ~(DIGITS'(1) << idx_q);
    if (blink_en && phase_q) begin
      an_d  = '1;
      seg_d = 7'b1111111;
    end else if (ovf_q) begin
      seg_d = 7'b0111111;
    end else if (blank_lz && (idx_q != '0) && hi_zero) begin
      seg_d = 7'b1111111;
    end else begin
      seg_d = seg_code(cur_nib);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cap_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      busy_q   <= 1'b0;
      disp_q   <= '0;
      ovf_q    <= 1'b0;
      div_q    <= '0;
      idx_q    <= '0;
      frm_q    <= '0;
      phase_q  <= 1'b0;
      seg_q    <= 7'b1111111;
      an_q     <= '1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cap_q    <= cap_d;
      bcd_q    <= bcd_d;
      iter_q   <= iter_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      busy_q   <= busy_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      frm_q    <= frm_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_display
// Purpose  : Self-checking bench for seg7_scan_display. A behavioural model
//            tracks the displayed number as an integer, conversion latency
//            as a countdown and the scan position from the cycle count;
//            expected seg/an codes come from decimal arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_display;

  localparam int DIGITS       = 2;
  localparam int IN_W         = 7;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [IN_W-1:0]   value = '0;
  logic              load = 1'b0;
  logic              blank_lz = 1'b0;
  logic              blink_en = 1'b0;
  logic              busy;
  logic              ovf;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  seg7_scan_display #(
    .DIGITS      (DIGITS),
    .IN_W        (IN_W),
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value   (value),
    .load    (load),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .busy    (busy),
    .ovf     (ovf),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  int m_n;        // rising edges since reset release
  int m_disp;     // displayed number (mod 10^DIGITS)
  bit m_ovf;
  bit m_busy;
  int m_rem;      // edges left until commit
  int m_cur;      // value being converted
  bit m_pv;
  int m_pend;
  bit m_phase;
  int m_fc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_n = 0; m_disp = 0; m_ovf = 0; m_busy = 0; m_rem = 0;
    m_cur = 0; m_pv = 0; m_pend = 0; m_phase = 0; m_fc = 0;
  endtask

  // Advance one clock edge, update the model and compare all outputs.
  task automatic tick();
    int         d_idx;
    int         pw;
    logic [6:0]        e_seg;
    logic [DIGITS-1:0] e_an;
    @(posedge clk);
    if (rst_n) begin
      m_reset();
      e_seg = 7'b1111111;
      e_an  = '1;
    end else begin
      m_n++;
      d_idx = ((m_n - 1) / SCAN_DIV) % DIGITS;
      pw    = 10 ** d_idx;
      if (blink_en && m_phase) begin
        e_an  = '1;
        e_seg = 7'b1111111;
      end else begin
        e_an = ~(DIGITS'(1) << d_idx);
        if (m_ovf)
          e_seg = 7'b0111111;
        else if (blank_lz && d_idx > 0 && (m_disp / pw) == 0)
          e_seg = 7'b1111111;
        else
          e_seg = seg_tab[(m_disp / pw) % 10];
      end
      // Blink phase flips once every BLINK_FRAMES complete frames.
      if (!blink_en) begin
        m_phase = 0;
        m_fc    = 0;
      end else if (m_n % (SCAN_DIV * DIGITS) == 0) begin
        m_fc++;
        if (m_fc == BLINK_FRAMES) begin
          m_fc    = 0;
          m_phase = !m_phase;
        end
      end
      // Conversion: IN_W+1 edges from capture to commit, one-deep pending.
      if (!m_busy) begin
        if (load) begin
          m_busy = 1; m_cur = int'(value); m_rem = IN_W + 1;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_disp = m_cur % (10 ** DIGITS);
          m_ovf  = (m_cur > 10 ** DIGITS - 1);
          if (m_pv) begin
            m_cur = m_pend; m_rem = IN_W + 1;
            m_pv  = load;
            if (load) m_pend = int'(value);
          end else if (load) begin
            m_cur = int'(value); m_rem = IN_W + 1;
          end else begin
            m_busy = 0;
          end
        end else if (load) begin
          m_pv = 1; m_pend = int'(value);
        end
      end
    end
    #1;
    check("busy", 32'(busy), 32'(m_busy));
    check("ovf",  32'(ovf),  32'(m_ovf));
    check("an",   32'(an),   32'(e_an));
    check("seg",  32'(seg),  32'(e_seg));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic do_load(input int v);
    value = IN_W'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (m_busy && guard < 100) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    int cnt;
    m_reset();

    // Reset state, then scanning of an all-zero display
    tick();
    tick();
    rst_n = 1'b0;
    idle(16);
    blank_lz = 1'b1;
    idle(8);
    blank_lz = 1'b0;

    // 37: busy duration and digit codes
    do_load(37);
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      tick();
    end
    check("busy_len", 32'(cnt), 32'(IN_W + 1));
    idle(16);

    // Leading-zero blanking; units digit never blanked
    blank_lz = 1'b1;
    do_load(5);  wait_done(); idle(16);
    do_load(40); wait_done(); idle(16);
    blank_lz = 1'b0;

    // Overflow dashes and recovery
    do_load(100); wait_done(); idle(16);
    check("ovf_100", 32'(ovf), 32'd1);
    do_load(99);  wait_done(); idle(16);
    check("ovf_99", 32'(ovf), 32'd0);

    // Load during conversion goes to pending
    do_load(12); tick(); do_load(34); wait_done(); idle(16);
    // Load on the commit edge itself
    do_load(55); idle(IN_W); do_load(66); wait_done(); idle(16);
    // Pending overwritten by a later load
    do_load(21); do_load(22); do_load(23); wait_done(); idle(16);

    // Blink
    blink_en = 1'b1;
    idle(40);
    blink_en = 1'b0;
    idle(8);

    // Asynchronous reset in the middle of a conversion
    do_load(88);
    idle(3);
    #3;
    rst_n = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_an",   32'(an),   32'(2'b11));
    check("arst_seg",  32'(seg),  32'(7'b1111111));
    m_reset();
    tick();
    rst_n = 1'b0;
    idle(16);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      load  = ($urandom_range(0, 5) == 0);
      value = IN_W'($urandom_range(0, 127));
      if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 80) == 0) blink_en = ~blink_en;
      tick();
    end
    load = 1'b0;
    wait_done();
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_display.md
# seg7_scan_display

Parametrised multi-digit countdown display driver for the traffic light controller. It accepts a binary count from the phase timer on a load strobe and converts it to BCD with a sequential double-dabble engine. It then drives a time-multiplexed, active-low common-anode 7-segment bank, one digit at a time. Leading-zero blanking, overflow dashes and a blink mode support the amber/flashing phases.

## Interface
- DIGITS, 2, number of display digits (1-4)
- IN_W, 6, width of binary input value (4-14)
- SCAN_DIV, 1000, clk cycles each digit stays enabled (>=2)
- BLINK_FRAMES, 50, full scan frames per blink half-period (>=1)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-high
- value  in  IN_W  binary count to display
- load  in  1  one-cycle strobe, capture value
- blank_lz  in  1  blank leading zeros when 1
- blink_en  in  1  blink whole display when 1
- busy  out  1  conversion in progress
- ovf  out  1  last committed value exceeded 10^DIGITS-1
- seg  out  7  segments g..a, active-low
- an  out  DIGITS  digit enables, active-low, one-hot-low or all-high

## Operation
- States: IDLE, CONV. Reset -> IDLE.
- IDLE, load=1: capture value into shift register, clear BCD scratch, iteration counter=0, busy<=1, go CONV.
- CONV: one double-dabble iteration per cycle (add 3 to every BCD nibble >=5, then shift left 1 bit), IN_W iterations. Then commit scratch BCD to display registers, set ovf<=(captured value > 10^DIGITS-1), busy<=0, go IDLE.
- Load during CONV: value is stored in a one-deep pending register, overwriting any earlier pending value. The pending value is captured on the commit cycle, busy stays 1, and a new conversion starts.
- Scan: divider counts 0..SCAN_DIV-1. On wrap, digit index advances 0..DIGITS-1 then back to 0 (digit 0 = units, rightmost).
- Frame counter increments when the index wraps from DIGITS-1 to 0. At BLINK_FRAMES frames it toggles blink phase and clears.
- Output decode for current index i, registered:
  - blink_en=1 and phase=1: an all high, seg=7'b1111111.
  - ovf=1: seg=7'b0111111 (dash) on every digit.
  - blank_lz=1, i>0, and digit i plus all higher digits are zero: seg=7'b1111111, an[i] still low.
  - otherwise: standard code 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Digit 0 is never blanked.
- blink_en=0 forces phase to 0 and clears the frame counter.

## Timing
- Reset (async assert) values: busy=0, ovf=0, seg=7'b1111111, an all high, display BCD=0, scan divider=0, index=0, blink phase=0, pending empty.
- First rising edge after reset release: an[0]=0, seg=1000000.
- seg/an lag index/display registers by 1 cycle, so they always change together.
- Load sampled at edge T in IDLE:
  - busy=1 after edge T.
  - Display registers and ovf update at edge T+IN_W+1.
  - busy=0 after edge T+IN_W+1.
  - Total latency is IN_W+1 cycles.
- A new value appears on a digit no earlier than the cycle after commit, when that digit is next scanned.
- Load and commit in the same cycle: the incoming value goes to pending and is converted next, with no loss.
- Reset asserted mid-conversion: conversion is aborted, pending is discarded, all state returns to reset values, and the old display value is not retained.
- value wider than DIGITS allows: conversion completes, ovf=1, and the BCD digits are not shown.

## Test plan
- Reset then idle, SCAN_DIV=4, DIGITS=2 -> an alternates 10,01 every 4 cycles; seg=1000000 on both digits when blank_lz=0; digit 1 seg=1111111 when blank_lz=1.
- Load value=37, IN_W=6 -> busy high exactly 7 cycles; then an=10 shows 1111000 (7) and an=01 shows 0110000 (3).
- Load 5 with blank_lz=1 -> digit 1 blank and digit 0 shows 0010010; load 40 -> digit 0 shows 1000000 (not blanked).
- IN_W=7, DIGITS=2, load 100 -> ovf=1 and both digits show 0111111; then load 99 -> ovf=0 and both digits show 0010000.
- Load 12 then load 34 two cycles later during CONV -> 12 commits, busy stays 1, 34 commits IN_W+1 cycles later, final display shows 34.
- blink_en=1, BLINK_FRAMES=1, SCAN_DIV=4, DIGITS=2 -> display on for 8 cycles, all off (an=11, seg=1111111) for 8 cycles, repeating; rst_n pulse mid-conversion -> busy=0, display 0.
